// File: rtl/mem_pkg.sv
// Shared defaults and port-index constants for the two-port memory arbiter.
package mem_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 1024;
  localparam int NPORTS     = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Consecutive waiting cycles after which a requester jumps the queue.
  localparam logic [3:0] STARVE_LIM = 4'd4;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a saturating wait counter per requester
// that forces a grant once a port has waited STARVE_LIM cycles.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic            prio_q, prio_d;
  logic [1:0][3:0] wait_q, wait_d;
  logic [1:0]      starved;
  logic [1:0]      raw;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NPORTS; i++)
      starved[i] = req[i] && (wait_q[i] >= STARVE_LIM);

    raw = '0;
    if (starved == 2'b11)   raw[prio_q] = 1'b1;
    else if (starved[0])    raw[PORT0]  = 1'b1;
    else if (starved[1])    raw[PORT1]  = 1'b1;
    else if (req == 2'b11)  raw[prio_q] = 1'b1;
    else                    raw         = req;

    // No grant may escape while the block is held in reset.
    gnt = rst_n ? raw : 2'b00;

    prio_d = prio_q;
    if (gnt[PORT0])      prio_d = PORT1;
    else if (gnt[PORT1]) prio_d = PORT0;

    wait_d = '0;
    for (int i = 0; i < NPORTS; i++)
      if (req[i] && !gnt[i])
        wait_d[i] = (wait_q[i] == 4'hF) ? 4'hF : wait_q[i] + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PORT0;
      wait_q <= '0;
    end else begin
      prio_q <= prio_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: one access per cycle, registered read data
// with latency 1, and an error pulse for out-of-range addresses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]              gnt;
  logic                    any_gnt, legal;
  logic                    sel_wr;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  logic [1:0]              rvalid_q, rvalid_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );

  assign gnt0 = gnt[PORT0];
  assign gnt1 = gnt[PORT1];

  always_comb begin
    any_gnt   = |gnt;
    sel_wr    = gnt[PORT1] ? wr1    : wr0;
    sel_addr  = gnt[PORT1] ? addr1  : addr0;
    sel_wdata = gnt[PORT1] ? wdata1 : wdata0;
    legal     = {1'b0, sel_addr} < DEPTH_L;

    // Every memory-side output is zeroed unless it carries a legal access.
    mem_we      = any_gnt && legal && sel_wr;
    mem_ren     = any_gnt && legal && !sel_wr;
    mem_waddr   = mem_we  ? sel_addr  : '0;
    mem_data_in = mem_we  ? sel_wdata : '0;
    mem_raddr   = mem_ren ? sel_addr  : '0;
  end

  always_comb begin
    rvalid_d = gnt & {2{mem_ren}};
    err_d    = gnt & {2{any_gnt && !legal}};
    rdata_d  = rdata_q;
    for (int i = 0; i < NPORTS; i++)
      if (rvalid_d[i]) rdata_d[i] = mem_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid0 = rvalid_q[PORT0];
  assign rvalid1 = rvalid_q[PORT1];
  assign err0    = err_q[PORT0];
  assign err1    = err_q[PORT1];
  assign rdata0  = rdata_q[PORT0];
  assign rdata1  = rdata_q[PORT1];

endmodule
